// File: rtl/axi_wr_burst_engine.sv
// AXI4 write-burst master: streams AXI-Stream beats into a DDR region as fixed-length INCR bursts,
// in one-shot or ring mode, with a bounded number of bursts awaiting their B response.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for write_start; status registers hold
// S_RUN   | issuing AWs (throttled by outstanding limit) and streaming W
// S_DRAIN | no new AWs; finishing open W bursts and collecting B responses
// S_DONE  | one-shot capture complete, cap_done held high
module axi_wr_burst_engine #(
  parameter int DATA_W          = 128,
  parameter int ADDR_W          = 32,
  parameter int BURST_LEN       = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  axi_aclk,
  input  logic                  axi_rstb,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awid,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  write_start,
  input  logic                  write_reset,
  input  logic                  ring_mode,
  input  logic [ADDR_W-1:0]     start_address,
  input  logic [31:0]           cap_size,
  output logic                  busy,
  output logic                  cap_done,
  output logic                  size_err,
  output logic                  bresp_err,
  output logic [ADDR_W-1:0]     current_addr,
  output logic [7:0]            run_cycles
);

  localparam int              BB   = BURST_LEN * DATA_W / 8;
  localparam logic [ADDR_W-1:0] BB_A = ADDR_W'(BB);

  if (BB > 4096 || BURST_LEN < 1 || BURST_LEN > 256 || DATA_W < 32 || DATA_W > 512 ||
      (DATA_W & (DATA_W - 1)) != 0 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16) begin : g_param_check
    $error("axi_wr_burst_engine: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [31:0]         n_bursts, burst_idx;
  logic [31:0]         aw_cnt, w_cnt, b_cnt;
  logic [7:0]          beat_cnt;
  logic                ring_q, rst_seen, awvalid_q;

  logic                w_en, aw_hs, w_hs, w_last_hs, b_hs;
  logic [31:0]         aw_cnt_nxt, w_cnt_nxt, b_cnt_nxt;
  logic                outstanding_ok, last_burst, drained;
  logic [31:0]         n_start;
  logic [ADDR_W-1:0]   base_start;

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(DATA_W / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awid    = 4'd0;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = 1'b1;

  // W beats only flow for bursts whose AW has already been accepted
  assign w_en          = w_cnt < aw_cnt;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wvalid  = s_axis_tvalid & w_en;
  assign s_axis_tready = m_axi_wready & w_en;
  assign m_axi_wlast   = w_en && (beat_cnt == 8'(BURST_LEN - 1));

  assign aw_hs     = awvalid_q & m_axi_awready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign w_last_hs = w_hs & m_axi_wlast;
  assign b_hs      = m_axi_bvalid;

  assign aw_cnt_nxt = aw_cnt + {31'd0, aw_hs};
  assign w_cnt_nxt  = w_cnt + {31'd0, w_last_hs};
  assign b_cnt_nxt  = b_cnt + {31'd0, b_hs};

  // Next-cycle counts so a B landing with an AW handshake keeps the throttle exact
  assign outstanding_ok = (aw_cnt_nxt - b_cnt_nxt) < 32'(MAX_OUTSTANDING);
  assign last_burst     = burst_idx == (n_bursts - 32'd1);
  assign drained        = !awvalid_q && (b_cnt_nxt == aw_cnt_nxt) && (w_cnt_nxt == aw_cnt_nxt);
  assign n_start        = cap_size / 32'(BB);
  assign base_start     = start_address - (start_address % BB_A);

  assign busy = (state == S_RUN) || (state == S_DRAIN);

  always_ff @(posedge axi_aclk or negedge axi_rstb) begin
    if (!axi_rstb) begin
      state        <= S_IDLE;
      base_addr    <= '0;
      awaddr_q     <= '0;
      n_bursts     <= '0;
      burst_idx    <= '0;
      aw_cnt       <= '0;
      w_cnt        <= '0;
      b_cnt        <= '0;
      beat_cnt     <= '0;
      ring_q       <= 1'b0;
      rst_seen     <= 1'b0;
      awvalid_q    <= 1'b0;
      cap_done     <= 1'b0;
      size_err     <= 1'b0;
      bresp_err    <= 1'b0;
      current_addr <= '0;
      run_cycles   <= '0;
    end else begin
      aw_cnt <= aw_cnt_nxt;
      w_cnt  <= w_cnt_nxt;
      b_cnt  <= b_cnt_nxt;
      if (w_hs) beat_cnt <= w_last_hs ? 8'd0 : beat_cnt + 8'd1;

      if (aw_hs) begin
        current_addr <= awaddr_q;
        if (last_burst) begin
          awaddr_q   <= base_addr;
          burst_idx  <= '0;
          run_cycles <= run_cycles + 8'd1;
        end else begin
          awaddr_q   <= awaddr_q + BB_A;
          burst_idx  <= burst_idx + 32'd1;
        end
      end

      if (write_reset) begin
        run_cycles   <= '0;
        current_addr <= '0;
        size_err     <= 1'b0;
        bresp_err    <= 1'b0;
        cap_done     <= 1'b0;
      end
      // an error arriving alongside a clear is kept rather than lost
      if (b_hs && m_axi_bresp != 2'b00) bresp_err <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (write_start && !write_reset) begin
            if (n_start == 32'd0) begin
              size_err <= 1'b1;
            end else begin
              state      <= S_RUN;
              base_addr  <= base_start;
              awaddr_q   <= base_start;
              n_bursts   <= n_start;
              ring_q     <= ring_mode;
              rst_seen   <= 1'b0;
              burst_idx  <= '0;
              aw_cnt     <= '0;
              w_cnt      <= '0;
              b_cnt      <= '0;
              beat_cnt   <= '0;
              run_cycles <= '0;
              cap_done   <= 1'b0;
              awvalid_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (write_reset) begin
            state    <= S_DRAIN;
            rst_seen <= 1'b1;
            if (aw_hs) awvalid_q <= 1'b0;
          end else if (!ring_q && aw_cnt_nxt == n_bursts) begin
            state     <= S_DRAIN;
            awvalid_q <= 1'b0;
          end else if (!awvalid_q || aw_hs) begin
            awvalid_q <= outstanding_ok;
          end
        end
        S_DRAIN: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (write_reset) rst_seen <= 1'b1;
          if (drained) begin
            if (rst_seen || write_reset) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DONE;
              cap_done <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
